// File: rtl/dice_pkg.sv
// Shared types and constants for the two-player dice game controller.
package dice_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_ROLL   = 3'd1;
  localparam state_t S_SETTLE = 3'd2;
  localparam state_t S_SCORE  = 3'd3;
  localparam state_t S_DONE   = 3'd4;

  localparam logic [2:0] THROW_MIN = 3'd1;
  localparam logic [2:0] THROW_MAX = 3'd6;

  typedef logic player_t;

  function automatic logic throw_ok(input logic [2:0] t);
    return (t >= THROW_MIN) && (t <= THROW_MAX);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; ptr names the player favoured on a tie.
module rr_arb2
  import dice_pkg::*;
(
  input  logic [1:0] req,
  input  player_t    ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/dice_game_ctrl.sv
// Two-player dice game controller: arbitrates rolls, drives the dice button,
// scores each throw and stops the game once a player reaches TARGET.
module dice_game_ctrl
  import dice_pkg::*;
#(
  parameter int TARGET   = 20,
  parameter int SCORE_W  = 5,
  parameter int MIN_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic               new_game,
  input  logic [2:0]         throw,
  output logic               dice_button,
  output logic [1:0]         grant,
  output logic               result_valid,
  output logic               result_player,
  output logic [2:0]         result_value,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic               game_over,
  output logic               winner,
  output logic               throw_err
);

  localparam int HOLD_W = $clog2(MIN_HOLD + 1);
  localparam logic [HOLD_W-1:0]  MIN_HOLD_C = HOLD_W'(MIN_HOLD);
  localparam logic [SCORE_W-1:0] TARGET_C   = SCORE_W'(TARGET);

  state_t              state_q, state_d;
  player_t             ptr_q, ptr_d;
  player_t             player_q, player_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                button_q, button_d;
  logic [1:0]          grant_q, grant_d;
  logic                rv_q, rv_d;
  player_t             rp_q, rp_d;
  logic [2:0]          rval_q, rval_d;
  logic [SCORE_W-1:0]  s0_q, s0_d, s1_q, s1_d;
  logic                go_q, go_d;
  player_t             win_q, win_d;
  logic                err_q, err_d;

  logic [1:0]          arb_grant;
  logic [SCORE_W-1:0]  cur_score, new_score;
  logic                valid_throw;

  rr_arb2 u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_grant)
  );

  always_comb begin
    valid_throw = throw_ok(throw);
    cur_score   = player_q ? s1_q : s0_q;
    new_score   = valid_throw ? cur_score + SCORE_W'(throw) : cur_score;

    state_d  = state_q;
    ptr_d    = ptr_q;
    player_d = player_q;
    hold_d   = hold_q;
    button_d = button_q;
    grant_d  = grant_q;
    rv_d     = 1'b0;
    rp_d     = rp_q;
    rval_d   = rval_q;
    s0_d     = s0_q;
    s1_d     = s1_q;
    go_d     = go_q;
    win_d    = win_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          state_d  = S_ROLL;
          grant_d  = arb_grant;
          player_d = arb_grant[1];
          button_d = 1'b1;
          hold_d   = HOLD_W'(1);
        end
      end
      S_ROLL: begin
        if (hold_q != '1) hold_d = hold_q + HOLD_W'(1);
        if (!req[player_q] && (hold_q >= MIN_HOLD_C)) begin
          state_d  = S_SETTLE;
          button_d = 1'b0;
          grant_d  = 2'b00;
        end
      end
      S_SETTLE: state_d = S_SCORE;
      S_SCORE: begin
        if (!valid_throw) err_d = 1'b1;
        if (player_q) s1_d = new_score;
        else          s0_d = new_score;
        rv_d   = 1'b1;
        rp_d   = player_q;
        rval_d = throw;
        ptr_d  = ~player_q;
        if (new_score >= TARGET_C) begin
          state_d = S_DONE;
          go_d    = 1'b1;
          win_d   = player_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    // new_game aborts whatever is in flight, including a pending result
    if (new_game) begin
      state_d  = S_IDLE;
      ptr_d    = 1'b0;
      hold_d   = '0;
      button_d = 1'b0;
      grant_d  = 2'b00;
      rv_d     = 1'b0;
      s0_d     = '0;
      s1_d     = '0;
      go_d     = 1'b0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b0;
      player_q <= 1'b0;
      hold_q   <= '0;
      button_q <= 1'b0;
      grant_q  <= 2'b00;
      rv_q     <= 1'b0;
      rp_q     <= 1'b0;
      rval_q   <= 3'd0;
      s0_q     <= '0;
      s1_q     <= '0;
      go_q     <= 1'b0;
      win_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      player_q <= player_d;
      hold_q   <= hold_d;
      button_q <= button_d;
      grant_q  <= grant_d;
      rv_q     <= rv_d;
      rp_q     <= rp_d;
      rval_q   <= rval_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      go_q     <= go_d;
      win_q    <= win_d;
      err_q    <= err_d;
    end
  end

  assign dice_button   = button_q;
  assign grant         = grant_q;
  assign result_valid  = rv_q;
  assign result_player = rp_q;
  assign result_value  = rval_q;
  assign score0        = s0_q;
  assign score1        = s1_q;
  assign game_over     = go_q;
  assign winner        = win_q;
  assign throw_err     = err_q;

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Scoreboard bench for dice_game_ctrl: rolls push expected results, a monitor
// pops and compares them whenever result_valid pulses.
module tb_dice_game_ctrl;

  localparam int TARGET   = 20;
  localparam int SCORE_W  = 5;
  localparam int MIN_HOLD = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         req;
  logic               new_game;
  logic [2:0]         throw;
  logic               dice_button;
  logic [1:0]         grant;
  logic               result_valid;
  logic               result_player;
  logic [2:0]         result_value;
  logic [SCORE_W-1:0] score0, score1;
  logic               game_over;
  logic               winner;
  logic               throw_err;

  dice_game_ctrl #(.TARGET(TARGET), .SCORE_W(SCORE_W), .MIN_HOLD(MIN_HOLD)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .new_game      (new_game),
    .throw         (throw),
    .dice_button   (dice_button),
    .grant         (grant),
    .result_valid  (result_valid),
    .result_player (result_player),
    .result_value  (result_value),
    .score0        (score0),
    .score1        (score1),
    .game_over     (game_over),
    .winner        (winner),
    .throw_err     (throw_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               p;
    logic [2:0]         v;
    logic [SCORE_W-1:0] s0;
    logic [SCORE_W-1:0] s1;
    logic               go;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_s0     = 0;
  int   m_s1     = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got result p=%0d v=%0d, required none", result_player, result_value);
      end else begin
        e = sb.pop_front();
        if ({result_player, result_value, score0, score1, game_over} !== {e.p, e.v, e.s0, e.s1, e.go}) begin
          n_fail++;
          $display("FAIL result: got p=%0d v=%0d s0=%0d s1=%0d go=%0d, required p=%0d v=%0d s0=%0d s1=%0d go=%0d",
                   result_player, result_value, score0, score1, game_over, e.p, e.v, e.s0, e.s1, e.go);
        end
      end
    end
  end

  // One roll requested in cycle 0 and released in cycle 1; waits for the result.
  task automatic roll(input int p, input logic [2:0] t, input logic [1:0] rq);
    exp_t e;
    int   lat;
    throw = t;
    req   = rq;
    if (t >= 3'd1 && t <= 3'd6) begin
      if (p == 0) m_s0 += int'(t);
      else        m_s1 += int'(t);
    end
    e.p  = (p != 0);
    e.v  = t;
    e.s0 = SCORE_W'(m_s0);
    e.s1 = SCORE_W'(m_s1);
    e.go = ((p == 0) ? m_s0 : m_s1) >= TARGET;
    sb.push_back(e);
    tick();
    req = 2'b00;
    lat = 1;
    while (result_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat != MIN_HOLD + 3) begin
      n_fail++;
      $display("FAIL roll_latency: got %0d cycles, required %0d", lat, MIN_HOLD + 3);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b00; new_game = 1'b0; throw = 3'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({dice_button, grant, result_valid, game_over, throw_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got btn=%0d gnt=%b rv=%0d go=%0d err=%0d, required all 0",
               dice_button, grant, result_valid, game_over, throw_err);
    end
    n_checks++;
    if ({score0, score1, result_player, result_value, winner} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got s0=%0d s1=%0d rp=%0d rval=%0d win=%0d, required all 0",
               score0, score1, result_player, result_value, winner);
    end
  endtask

  task automatic test_alternation();
    exp_t e;
    int   cnt;
    int   lat;
    throw = 3'd4;
    req   = 2'b11;
    m_s0 = 4;
    e.p = 1'b0; e.v = 3'd4; e.s0 = 5'd4; e.s1 = 5'd0; e.go = 1'b0;
    sb.push_back(e);
    tick();
    n_checks++;
    if (grant !== 2'b01 || dice_button !== 1'b1) begin
      n_fail++;
      $display("FAIL first_grant: got gnt=%b btn=%0d, required gnt=01 btn=1", grant, dice_button);
    end
    req = 2'b00;
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dice_button === 1'b1) cnt++;
      else break;
    end
    n_checks++;
    if (cnt != MIN_HOLD) begin
      n_fail++;
      $display("FAIL button_len: got %0d, required %0d", cnt, MIN_HOLD);
    end
    tick(); tick();
    n_checks++;
    if (result_valid !== 1'b1 || score0 !== 5'd4) begin
      n_fail++;
      $display("FAIL cycle7_result: got rv=%0d s0=%0d, required rv=1 s0=4", result_valid, score0);
    end
    throw = 3'd5;
    req   = 2'b11;
    m_s1 = 5;
    e.p = 1'b1; e.v = 3'd5; e.s0 = 5'd4; e.s1 = 5'd5; e.go = 1'b0;
    sb.push_back(e);
    tick();
    n_checks++;
    if (grant !== 2'b10) begin
      n_fail++;
      $display("FAIL rr_grant: got %b, required 10", grant);
    end
    req = 2'b00;
    lat = 1;
    while (result_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat != MIN_HOLD + 3) begin
      n_fail++;
      $display("FAIL rr_latency: got %0d, required %0d", lat, MIN_HOLD + 3);
    end
  endtask

  task automatic test_long_hold();
    exp_t e;
    int   cnt;
    logic [3:0] rv_seq;
    throw = 3'd2;
    req   = 2'b01;
    m_s0 += 2;
    e.p = 1'b0; e.v = 3'd2; e.s0 = SCORE_W'(m_s0); e.s1 = SCORE_W'(m_s1); e.go = 1'b0;
    sb.push_back(e);
    cnt = 0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (dice_button === 1'b1) cnt++;
    end
    req = 2'b00;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dice_button === 1'b1) cnt++;
      else break;
    end
    n_checks++;
    if (cnt != 11) begin
      n_fail++;
      $display("FAIL long_button_len: got %0d, required 11", cnt);
    end
    rv_seq[3] = result_valid;
    tick(); rv_seq[2] = result_valid;
    tick(); rv_seq[1] = result_valid;
    tick(); rv_seq[0] = result_valid;
    n_checks++;
    if (rv_seq !== 4'b0010) begin
      n_fail++;
      $display("FAIL long_rv_pulse: got %b, required 0010", rv_seq);
    end
  endtask

  task automatic test_throw_err();
    roll(0, 3'd0, 2'b01);
    n_checks++;
    if (throw_err !== 1'b1 || score0 !== SCORE_W'(m_s0)) begin
      n_fail++;
      $display("FAIL bad_throw: got err=%0d s0=%0d, required err=1 s0=%0d", throw_err, score0, m_s0);
    end
    roll(1, 3'd3, 2'b10);
    n_checks++;
    if (throw_err !== 1'b1 || score1 !== SCORE_W'(m_s1)) begin
      n_fail++;
      $display("FAIL err_sticky: got err=%0d s1=%0d, required err=1 s1=%0d", throw_err, score1, m_s1);
    end
  endtask

  task automatic test_win();
    int bad;
    roll(0, 3'd6, 2'b01);
    roll(0, 3'd6, 2'b01);
    n_checks++;
    if (score0 !== 5'd18 || game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_win: got s0=%0d go=%0d, required s0=18 go=0", score0, game_over);
    end
    roll(0, 3'd3, 2'b01);
    n_checks++;
    if (game_over !== 1'b1 || winner !== 1'b0 || score0 !== 5'd21) begin
      n_fail++;
      $display("FAIL win: got go=%0d win=%0d s0=%0d, required go=1 win=0 s0=21", game_over, winner, score0);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      req = (i % 2 == 0) ? 2'b11 : 2'b00;
      tick();
      if (grant !== 2'b00 || dice_button !== 1'b0 || game_over !== 1'b1) bad++;
    end
    req = 2'b00;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL done_ignores_req: got %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_new_game();
    int bad;
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    m_s0 = 0; m_s1 = 0;
    n_checks++;
    if ({game_over, throw_err, score0, score1} !== '0) begin
      n_fail++;
      $display("FAIL new_game_done: got go=%0d err=%0d s0=%0d s1=%0d, required all 0",
               game_over, throw_err, score0, score1);
    end
    roll(0, 3'd2, 2'b01);
    req = 2'b01;
    tick();
    tick();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    req = 2'b00;
    m_s0 = 0;
    n_checks++;
    if (dice_button !== 1'b0 || grant !== 2'b00 || score0 !== '0) begin
      n_fail++;
      $display("FAIL abort: got btn=%0d gnt=%b s0=%0d, required btn=0 gnt=00 s0=0", dice_button, grant, score0);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (result_valid !== 1'b0 || dice_button !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: got %0d active cycles, required 0", bad);
    end
    roll(0, 3'd1, 2'b11);
  endtask

  task automatic test_rst_score();
    throw = 3'd6;
    req   = 2'b10;
    tick();
    req = 2'b00;
    repeat (5) tick();
    rst = 1'b1;
    new_game = 1'b1;
    tick();
    rst = 1'b0;
    new_game = 1'b0;
    m_s0 = 0; m_s1 = 0;
    n_checks++;
    if ({dice_button, grant, result_valid, result_player, result_value, score0, score1,
         game_over, winner, throw_err} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_score: got btn=%0d gnt=%b rv=%0d rp=%0d rval=%0d s0=%0d s1=%0d go=%0d win=%0d err=%0d, required all 0",
               dice_button, grant, result_valid, result_player, result_value, score0, score1,
               game_over, winner, throw_err);
    end
    roll(0, 3'd4, 2'b11);
  endtask

  initial begin
    test_reset();
    test_alternation();
    test_long_hold();
    test_throw_err();
    test_win();
    test_new_game();
    test_rst_score();
    tick(); tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dice_game_ctrl.md
# dice_game_ctrl

Two-player controller for the electronic dice block. It arbitrates roll requests from two players round-robin and drives the dice `button` input for the granted player. When the roll ends it samples `throw`, checks the value, and accumulates a per-player score. The game stops when a player reaches the target score. It sits between the player push-button inputs and a single dice instance, which shares the system `clk`/`rst`.

## Interface
- `TARGET`, default 20: winning score threshold (≥).
- `SCORE_W`, default 5: score width; must satisfy 2^SCORE_W > TARGET+5.
- `MIN_HOLD`, default 4: minimum number of cycles `dice_button` is held per roll (≥1).
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req` in 2: per-player roll request, level; bit i = player i.
- `new_game` in 1: single-cycle pulse that clears scores and restarts.
- `throw` in 3: current dice value from the dice block.
- `dice_button` out 1: drives the dice `button`.
- `grant` out 2: one-hot, the player currently rolling; 0 when no roll.
- `result_valid` out 1: one-cycle pulse, roll scored.
- `result_player` out 1: player of last result.
- `result_value` out 3: throw value of last result.
- `score0`, `score1` out SCORE_W: accumulated scores.
- `game_over` out 1: high in DONE.
- `winner` out 1: winning player, valid while `game_over`.
- `throw_err` out 1: sticky; a sampled throw was outside 1..6.

## Operation
- FSM states: IDLE, ROLL, SETTLE, SCORE, DONE. All outputs are registered.
- **IDLE**
  - If `req` != 0, grant one player and go to ROLL.
  - If only one player requests, that player is granted.
  - If both request, the player selected by the priority pointer `ptr` is granted.
- **ROLL**
  - `dice_button`=1 and `grant` is held.
  - `hold_cnt` counts ROLL cycles from 1, saturating.
  - Exit to SETTLE after a cycle where `req[granted]`=0 and `hold_cnt` ≥ MIN_HOLD.
  - `req` from the other player is ignored; it stays pending only if still held.
- **SETTLE**
  - `dice_button`=0 for one cycle so the final dice increment lands.
- **SCORE**
  - Sample `throw`.
  - If the value is in 1..6, add it to the granted player's score. Arithmetic is unsigned, zero-extended to SCORE_W, with no wrap under the parameter rule.
  - Otherwise the score is unchanged and `throw_err` is set.
  - Either way, `result_valid`, `result_player` and `result_value` are set on the exit edge.
  - `ptr` is set to the other player.
  - Go to DONE if the updated score ≥ TARGET, else IDLE.
- **DONE**
  - `game_over`=1 and `winner` is held; `req` is ignored.
  - The only exits are `new_game` or `rst`.
- **`new_game`**
  - Accepted in any state.
  - Next edge: scores=0, `ptr`=0, `throw_err`=0, state IDLE, `dice_button`=0, `grant`=0.
  - A roll in progress is aborted and no `result_valid` is produced.
- **`rst`**
  - Same effect as `new_game`. In addition, `result_player`, `result_value` and `winner` go to 0.
  - `rst` has priority over `new_game`.
- **Reset values:** all outputs 0; state IDLE; `ptr`=0.

## Timing
- `req` rises in cycle 0 while in IDLE: `grant` and `dice_button` are high from cycle 1.
- With MIN_HOLD=4 and `req` released early, the ROLL cycles are 1..4, SETTLE is cycle 5, SCORE is cycle 6, and `result_valid` is high in cycle 7, with scores already updated in cycle 7.
- If `req` is held for N > MIN_HOLD cycles, ROLL spans cycles 1..N+1 (exit once `req`=0 is observed).
- `result_valid` is never high for two consecutive cycles.
- The minimum spacing between results is MIN_HOLD+3 cycles.
- `game_over` rises in the same cycle as the winning `result_valid`.
- A `req` still held in the cycle after SCORE→IDLE starts a new roll one cycle later.

## Structure
- Package `dice_pkg`:
  - state enum;
  - constants THROW_MIN=1, THROW_MAX=6;
  - player index type.
- Sub-module `rr_arb2`:
  - two-requester round-robin arbiter;
  - inputs `req[1:0]`, `ptr`; output one-hot grant;
  - combinational, with the pointer register held in the parent.
- FSM, counters and score registers live in `dice_game_ctrl`.

## Test plan
- Both `req`=2'b11 after reset, `throw`=4: player 0 is granted, `dice_button` is high for exactly 4 cycles, `result_valid` is seen in cycle 7 with `score0`=4. Both requests held again: player 1 is granted next.
- `req0` held for 10 cycles: `dice_button` is high for 11 cycles, then SETTLE, SCORE, and a single `result_valid` pulse.
- `throw`=0 at SCORE: `throw_err`=1 and stays set, score unchanged, `result_value`=0; the next roll scores normally.
- Player 0 at 18 rolls a 3: `score0`=21, `game_over`=1 and `winner`=0 in the same cycle as `result_valid`; further `req` pulses produce no `grant`.
- `new_game` pulse in the 2nd ROLL cycle: `dice_button`=0 next cycle, scores 0, IDLE, no `result_valid`.
- `rst` and `new_game` together mid-SCORE: all outputs 0 next cycle, `ptr`=0, no score update.
